// File: rtl/sram_controller.sv
// sram_controller: turns 32-bit word requests into two 16-bit SRAM accesses
// (low halfword, then high halfword). Two wait states and a one-cycle
// completion state follow the two accesses.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   write_en, read_en   - level-held requests, kept high until ready
//   address             - byte address; the data space starts at byte 1024
//   write_data          - word to store
//   read_data           - last word read; cleared by reset
//   ready               - 1 when idle with no request, or in the completion cycle
//   SRAM_DQ             - bidirectional SRAM data bus
//   SRAM_ADDR           - SRAM halfword address
//   SRAM_*_N            - active-low SRAM strobes
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int unsigned DATA_BASE = 1024;
    localparam int unsigned EFF_W     = 19;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_WAIT1 = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        op_write_q, op_write_d;
    logic [31:0] read_data_q, read_data_d;

    logic             half_sel;
    logic             dq_oe;
    logic [15:0]      dq_out;
    logic [EFF_W-1:0] eff;
    logic             unused_addr_bits;

    // Only eff[18:2] reaches the SRAM; low bits of a subtraction depend only
    // on low operand bits, so the top address bits never matter.
    assign eff              = address[EFF_W-1:0] - EFF_W'(DATA_BASE);
    assign unused_addr_bits = ^{address[31:EFF_W], eff[1:0]};

    assign SRAM_ADDR = {eff[EFF_W-1:2], half_sel};
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign dq_out  = half_sel ? write_data[31:16] : write_data[15:0];
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    assign read_data = read_data_q;

    // State, latched operation type and read data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            read_data_q <= read_data_d;
        end
    end

    // Next state, strobes and read-data capture.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        SRAM_WE_N   = 1'b1;
        half_sel    = 1'b0;
        dq_oe       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (write_en || read_en) begin
                    state_d    = ST_LOW;
                    op_write_d = write_en;   // write wins over a simultaneous read
                end else begin
                    ready = 1'b1;
                end
            end
            ST_LOW: begin
                state_d = ST_HIGH;
                if (op_write_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                end else begin
                    read_data_d[15:0] = SRAM_DQ;
                end
            end
            ST_HIGH: begin
                state_d  = ST_WAIT1;
                half_sel = 1'b1;
                if (op_write_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                end else begin
                    read_data_d[31:16] = SRAM_DQ;
                end
            end
            ST_WAIT1: state_d = ST_WAIT2;
            ST_WAIT2: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                ready   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an SRAM array lives in the bench, a transaction
// model predicts the pins every cycle, and directed vectors pin exact values.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] address = 32'd1024;
    logic [31:0] write_data = 32'd0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         ub_n, lb_n, we_n, ce_n, oe_n;

    int n_total = 0;
    int n_pass  = 0;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .read_en    (read_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_WE_N  (we_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_OE_N  (oe_n)
    );

    always #5 clk = ~clk;

    // SRAM array: preloaded with a pattern on the first edge, never cleared by rst.
    logic [15:0] mem [0:262143];
    logic        mem_init = 1'b0;

    function automatic logic [15:0] pattern(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 262144; i++) mem[i] <= pattern(i);
            mem_init <= 1'b1;
        end else if (!we_n) begin
            mem[sram_addr] <= sram_dq;
        end
    end

    assign sram_dq = we_n ? mem[sram_addr] : 16'hzzzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Transaction model: m_phase counts clocks since the starting edge (0 = idle).
    int              m_phase = 0;
    logic            m_wr = 1'b0;
    logic [31:0]     m_rd = 32'd0;
    logic [15:0]     m_mem [int];

    function automatic logic [15:0] mval(input int a);
        return m_mem.exists(a) ? m_mem[a] : pattern(a);
    endfunction

    function automatic int base_half(input logic [31:0] a);
        logic [31:0] e;
        e = a - 32'd1024;
        return int'(e[18:2]) * 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_rd    = 32'd0;
        end else begin
            if (m_phase == 0) begin
                if (write_en || read_en) begin
                    m_phase = 1;
                    m_wr    = write_en;
                end
            end else begin
                if (m_phase == 1 || m_phase == 2) begin
                    int ha;
                    ha = base_half(address) + m_phase - 1;
                    if (m_wr)
                        m_mem[ha] = (m_phase == 1) ? write_data[15:0] : write_data[31:16];
                    else if (m_phase == 1)
                        m_rd[15:0] = mval(ha);
                    else
                        m_rd[31:16] = mval(ha);
                end
                m_phase = (m_phase == 5) ? 0 : m_phase + 1;
            end
        end
    end

    // Per-cycle comparison of every pin against the model.
    always @(negedge clk) begin
        logic        e_ready;
        logic        e_drive;
        int          e_ha;
        logic [15:0] e_dq;
        e_ready = (m_phase == 0 && !write_en && !read_en) || m_phase == 5;
        e_drive = m_wr && (m_phase == 1 || m_phase == 2);
        e_ha    = base_half(address) + ((m_phase == 2) ? 1 : 0);
        if (e_drive)
            e_dq = (m_phase == 1) ? write_data[15:0] : write_data[31:16];
        else
            e_dq = mval(e_ha);
        chk("ready",     32'(ready), 32'(e_ready));
        chk("we_n",      32'(we_n), 32'(!e_drive));
        chk("sram_addr", 32'(sram_addr), 32'(18'(e_ha)));
        chk("sram_dq",   32'(sram_dq), 32'(e_dq));
        chk("read_data", read_data, m_rd);
        chk("strobes",   32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
    end

    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, output int rlow, output int wlow,
                             output logic [31:0] rdv);
        logic done;
        @(posedge clk); #1;
        write_en = w; read_en = r; address = a; write_data = d;
        rlow = 0; wlow = 0; rdv = 32'd0; done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                rdv  = read_data;
                done = 1'b1;
                break;
            end
            rlow++;
            if (!we_n) wlow++;
        end
        chk("access_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
        write_en = 1'b0; read_en = 1'b0;
    endtask

    int          rl, wl, idle_bad;
    logic [31:0] rv;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(we_n), 32'd1);

        // Basic write then read at byte 1029 (halfwords 2 and 3).
        do_access(1'b1, 1'b0, 32'd1029, 32'h0002_0001, rl, wl, rv);
        chk("wr_ready_low_cycles", 32'(rl), 32'd5);
        chk("wr_we_low_cycles", 32'(wl), 32'd2);
        chk("wr_mem2", 32'(mem[2]), 32'h0001);
        chk("wr_mem3", 32'(mem[3]), 32'h0002);
        do_access(1'b0, 1'b1, 32'd1029, 32'd0, rl, wl, rv);
        chk("rd_ready_low_cycles", 32'(rl), 32'd5);
        chk("rd_we_low_cycles", 32'(wl), 32'd0);
        chk("rd_data", rv, 32'h0002_0001);

        // Address map: byte offset within the word is ignored.
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, rl, wl, rv);
        do_access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, rl, wl, rv);
        chk("map_mem0", 32'(mem[0]), 32'hBEEF);
        chk("map_mem1", 32'(mem[1]), 32'hDEAD);
        chk("map_mem2", 32'(mem[2]), 32'h5678);
        chk("map_mem3", 32'(mem[3]), 32'h1234);
        do_access(1'b0, 1'b1, 32'd1027, 32'd0, rl, wl, rv);
        chk("map_rd_1027", rv, 32'hDEAD_BEEF);

        // Simultaneous enables: write performed, read data untouched.
        do_access(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, rl, wl, rv);
        chk("both_we_low_cycles", 32'(wl), 32'd2);
        chk("both_read_data", rv, 32'hDEAD_BEEF);
        chk("both_mem0", 32'(mem[0]), 32'hF00D);
        chk("both_mem1", 32'(mem[1]), 32'hCAFE);

        // Reset during WAIT1 of a read.
        @(posedge clk); #1;
        read_en = 1'b1; address = 32'd1029;
        repeat (3) @(posedge clk);
        #1;
        read_en = 1'b0; address = 32'd1024; rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        chk("rst_mid_we_n", 32'(we_n), 32'd1);
        chk("rst_mid_read_data", read_data, 32'd0);
        chk("rst_mid_addr", 32'(sram_addr), 32'd0);
        chk("rst_mid_dq", 32'(sram_dq), 32'(mem[0]));
        #1 rst = 1'b0;
        do_access(1'b0, 1'b1, 32'd1029, 32'd0, rl, wl, rv);
        chk("post_rst_ready_low", 32'(rl), 32'd5);
        chk("post_rst_rd", rv, 32'h1234_5678);

        // Idle for 10 clocks.
        idle_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ready || !we_n) idle_bad++;
        end
        chk("idle_quiet", 32'(idle_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
